alu_execute_unit: RTL and testbench
===================================

Name: alu_execute_unit

Overview:
- EX-stage consumer of the 4-bit ALU control code: takes ALUCnt plus two operands and produces a registered result and NZCV flags.
- Single-cycle ops (AND, ORR, ADD, SUB, pass-B, NOR) complete in one cycle.
- MUL runs on an iterative shift-add engine and stalls the pipeline while busy.
- Sits between ID/EX and EX/MEM; the stall output feeds the hazard unit.

Parameters:
- WIDTH, 64, operand/result width in bits (must be a power of two, >= 8).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  synchronous kill of any in-flight/accepting op
- in_valid  input  1  ID/EX presents an op this cycle
- in_ready  output  1  unit can accept an op this cycle
- alu_cnt  input  4  ALU control code
- op_a  input  WIDTH  operand A (Rn)
- op_b  input  WIDTH  operand B (Rm / immediate / Rt)
- result  output  WIDTH  registered result, held until next completion
- flag_n, flag_z, flag_c, flag_v  output  1 each  registered NZCV for result
- out_valid  output  1  one-cycle pulse per completed op
- illegal_op  output  1  registered with result; high if alu_cnt undefined
- stall  output  1  high while MUL engine busy (== !in_ready)

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; result=0; NZCV=0; out_valid=0; illegal_op=0; in_ready=1; stall=0; multiplier counters cleared.
- Codes:
  - 0000 AND
  - 0001 ORR
  - 0010 ADD
  - 0110 SUB (A + ~B + 1)
  - 0111 pass-B (CBZ)
  - 1100 NOR
  - 1000 MUL (low WIDTH bits of A*B)
  - All other codes illegal.
- Accept = in_valid & in_ready & !flush at a rising edge (edge 0).
- Single-cycle or illegal op: result/flags/out_valid=1 registered at edge 0; out_valid drops at the next edge unless another op is accepted there. Back-to-back accepts every cycle give continuous out_valid.
- Illegal op: result=0, N=0, Z=1, C=0, V=0, illegal_op=1.
- Flags:
  - N=result[WIDTH-1]; Z=(result==0).
  - ADD: C=carry out of MSB; V=signed overflow.
  - SUB: C=1 when no borrow (A>=B unsigned); V=signed overflow.
  - Logical, pass-B and MUL: C=0, V=0.
- MUL FSM: states IDLE, MUL_RUN.
  - IDLE --accept MUL--> MUL_RUN at edge 0: latch mcand=A, mplier=B, acc=0, cnt=0; out_valid=0.
  - MUL_RUN, each edge k=1..WIDTH: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
  - At edge WIDTH: result=final acc, flags set, out_valid=1, next state IDLE.
  - in_ready=0 / stall=1 in every cycle while in MUL_RUN; in_ready returns high in the cycle after edge WIDTH.
  - Total latency: WIDTH cycles from accepting edge to out_valid.
  - No early termination; latency is fixed and independent of operand values.
- in_valid while busy is ignored; upstream must hold the op (stall).
- flush at an edge:
  - Kills any MUL_RUN and returns to IDLE.
  - Blocks acceptance that cycle; out_valid=0.
  - result/flags keep their old values.
- flush and rst_n both active: reset wins.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- alu_cnt and operands are sampled only at the accepting edge; changes during MUL_RUN have no effect.

Decomposition:
- Shared package alu_pkg:
  - ALU control code localparams (ALU_AND=4'b0000, ALU_ORR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111, ALU_NOR=4'b1100, ALU_MUL=4'b1000).
  - FSM state encoding (ST_IDLE, ST_MUL_RUN).
- Sub-module alu_seq_multiplier:
  - start/done handshake, WIDTH parameter; owns the mcand/mplier/acc/cnt registers.
  - The top level holds the FSM, the combinational ops, flag logic and output registers.

Test Plan:
- WIDTH=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> next cycle result=0x8000_0000_0000_0000, N=1 Z=0 C=0 V=1, out_valid 1 cycle.
- SUB A=5, B=5 -> result=0, Z=1, C=1, V=0; then SUB A=3, B=5 -> result=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- MUL A=12345, B=678 accepted at edge 0 -> stall=1 for cycles 1..64; in_valid ignored meanwhile; out_valid at edge 64 with result=8369910, C=V=0; in_ready=1 after edge 64.
- Back-to-back AND(0xF0,0x3C), ORR(0xF0,0x0F), NOR(0,0), pass-B(0) -> results 0x30, 0xFF, all-ones (N=1), 0 (Z=1); out_valid high 4 consecutive cycles.
- MUL accepted, flush at cycle 10 -> no out_valid, in_ready=1 next cycle, result still holds the prior value; a new ADD 2+2 accepted then -> result 4.
- alu_cnt=4'b1111 -> illegal_op=1, result=0, Z=1; rst_n=0 mid-MUL (cycle 20) -> all outputs 0 and in_ready=1 after that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: control codes and the multiply FSM encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_MUL_RUN
  } alu_state_e;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, fixed WIDTH-cycle latency.
module alu_seq_multiplier #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nxt;
  logic [CntW-1:0]  cnt_q;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The last step's sum goes straight out so the result lands on the WIDTH-th edge.
  assign product = acc_nxt;
  assign done    = run && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (run) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end else if (kill) begin
      cnt_q    <= '0;
    end
  end

endmodule

// File: rtl/alu_execute_unit.sv
// EX-stage ALU: single-cycle logic/arith ops plus a stalling multi-cycle MUL, registered NZCV.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             out_valid,
  output logic             illegal_op,
  output logic             stall
);

  alu_state_e state_q, state_d;

  logic             accept, is_mul, mul_start, mul_run, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, alu_c, alu_v, alu_illegal;

  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             out_valid_q, out_valid_d, illegal_q, illegal_d;

  assign is_mul    = (alu_cnt == ALU_MUL);
  assign accept    = in_valid && in_ready && !flush;
  assign mul_start = accept && is_mul;
  assign mul_run   = (state_q == ST_MUL_RUN) && !flush;

  alu_seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .run     (mul_run),
    .kill    (flush),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (mul_start) state_d = ST_MUL_RUN;
      ST_MUL_RUN: if (flush || mul_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    stall    = !in_ready;
  end

  // SUB is A + ~B + 1 so carry-out doubles as the "no borrow" flag.
  always_comb begin
    cin         = (alu_cnt == ALU_SUB);
    b_eff       = cin ? ~op_b : op_b;
    sum         = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_illegal = 1'b0;
    case (alu_cnt)
      ALU_AND:   alu_res = op_a & op_b;
      ALU_ORR:   alu_res = op_a | op_b;
      ALU_ADD, ALU_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(op_a | op_b);
      ALU_MUL:   alu_res = '0;
      default:   alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    if (accept && !is_mul) begin
      result_d    = alu_res;
      n_d         = alu_res[WIDTH-1];
      z_d         = (alu_res == '0);
      c_d         = alu_c;
      v_d         = alu_v;
      illegal_d   = alu_illegal;
      out_valid_d = 1'b1;
    end else if (mul_done) begin
      result_d    = mul_product;
      n_d         = mul_product[WIDTH-1];
      z_d         = (mul_product == '0);
      c_d         = 1'b0;
      v_d         = 1'b0;
      illegal_d   = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result     = result_q;
  assign flag_n     = n_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign flag_v     = v_q;
  assign illegal_op = illegal_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit at WIDTH=64 with hand-computed expectations.
module tb_alu_execute_unit;

  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready;
  logic [3:0]       alu_cnt;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic             flag_n, flag_z, flag_c, flag_v, out_valid, illegal_op, stall;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pulses;

  always #5 clk = ~clk;

  alu_execute_unit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_cnt    (alu_cnt),
    .op_a       (op_a),
    .op_b       (op_b),
    .result     (result),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .out_valid  (out_valid),
    .illegal_op (illegal_op),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cnt, input logic [63:0] a,
                       input logic [63:0] b);
    in_valid = v;
    alu_cnt  = cnt;
    op_a     = a;
    op_b     = b;
  endtask

  function automatic logic [3:0] nzcv();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    step();
    check("rst_result", result, 64'd0);
    check("rst_nzcv", {60'd0, nzcv()}, 64'h0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_illegal", {63'd0, illegal_op}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    rst_n = 1'b1;
    step();

    // ADD with signed overflow
    drive(1'b1, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    check("add_ovf_result", result, 64'h8000_0000_0000_0000);
    check("add_ovf_nzcv", {60'd0, nzcv()}, 64'h9);
    check("add_ovf_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    check("add_ovf_valid_drop", {63'd0, out_valid}, 64'd0);
    check("add_ovf_hold", result, 64'h8000_0000_0000_0000);

    drive(1'b1, 4'b0110, 64'd5, 64'd5);
    step();
    check("sub_eq_result", result, 64'd0);
    check("sub_eq_nzcv", {60'd0, nzcv()}, 64'h6);
    drive(1'b1, 4'b0110, 64'd3, 64'd5);
    step();
    check("sub_lt_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_lt_nzcv", {60'd0, nzcv()}, 64'h8);
    check("sub_lt_valid", {63'd0, out_valid}, 64'd1);

    // MUL: stalls cycles 1..64, ignores in_valid meanwhile
    drive(1'b1, 4'b1000, 64'd12345, 64'd678);
    step();
    check("mul_edge0_stall", {63'd0, stall}, 64'd1);
    check("mul_edge0_valid", {63'd0, out_valid}, 64'd0);
    drive(1'b1, 4'b0010, 64'd1, 64'd1);
    for (int k = 1; k < 64; k++) begin
      step();
      check($sformatf("mul_busy_%0d", k), {62'd0, stall, out_valid}, 64'h2);
    end
    step();
    check("mul_valid", {63'd0, out_valid}, 64'd1);
    check("mul_result", result, 64'd8369910);
    check("mul_nzcv", {60'd0, nzcv()}, 64'h0);
    check("mul_in_ready", {63'd0, in_ready}, 64'd1);
    check("mul_stall_low", {63'd0, stall}, 64'd0);
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    check("mul_valid_drop", {63'd0, out_valid}, 64'd0);
    check("mul_hold", result, 64'd8369910);

    // back-to-back single-cycle ops
    drive(1'b1, 4'b0000, 64'hF0, 64'h3C);
    step();
    check("and_result", result, 64'h30);
    check("and_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'b0001, 64'hF0, 64'h0F);
    step();
    check("orr_result", result, 64'hFF);
    check("orr_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'b1100, 64'd0, 64'd0);
    step();
    check("nor_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nor_nzcv", {60'd0, nzcv()}, 64'h8);
    check("nor_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'b0111, 64'h1234, 64'd0);
    step();
    check("passb_result", result, 64'd0);
    check("passb_nzcv", {60'd0, nzcv()}, 64'h4);
    check("passb_valid", {63'd0, out_valid}, 64'd1);

    drive(1'b1, 4'b0010, 64'd100, 64'd23);
    step();
    check("add_123", result, 64'd123);
    // flush blocks acceptance
    drive(1'b1, 4'b0010, 64'd1, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_block_valid", {63'd0, out_valid}, 64'd0);
    check("flush_block_hold", result, 64'd123);

    // MUL killed by flush at cycle 10
    drive(1'b1, 4'b1000, 64'd3, 64'd4);
    step();
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mflush_valid", {63'd0, out_valid}, 64'd0);
    check("mflush_in_ready", {63'd0, in_ready}, 64'd1);
    check("mflush_hold", result, 64'd123);
    drive(1'b1, 4'b0010, 64'd2, 64'd2);
    step();
    check("mflush_add_result", result, 64'd4);
    check("mflush_add_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (out_valid) pulses++;
    end
    check("mflush_no_late_valid", 64'(pulses), 64'd0);
    check("mflush_late_hold", result, 64'd4);

    drive(1'b1, 4'b1111, 64'd9, 64'd9);
    step();
    check("illegal_flag", {63'd0, illegal_op}, 64'd1);
    check("illegal_result", result, 64'd0);
    check("illegal_nzcv", {60'd0, nzcv()}, 64'h4);
    check("illegal_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'b0110, 64'd3, 64'd5);
    step();
    check("illegal_clear", {63'd0, illegal_op}, 64'd0);
    check("pre_rst_result", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // reset in the middle of a MUL
    drive(1'b1, 4'b1000, 64'd12345, 64'd678);
    step();
    drive(1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (19) step();
    check("mrst_stall_before", {63'd0, stall}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_result", result, 64'd0);
    check("mrst_nzcv", {60'd0, nzcv()}, 64'h0);
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mrst_stall", {63'd0, stall}, 64'd0);
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (out_valid) pulses++;
    end
    check("mrst_no_late_valid", 64'(pulses), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
